seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin scan scheduler for an 8-digit, active-low
// seven-segment display sharing one segment bus.
//
// Each digit slot is BLANK cycles of all-dark followed by DWELL cycles with
// that digit driven. Digit data is double-buffered: a load lands in a
// pending buffer and is promoted to the active buffer only at the frame
// boundary (SHOW of digit 7 -> BLANK of digit 0), so every frame shows
// data from a single load.
//
// Registered outputs are computed from the next state, so they change on
// the same edge as the state itself with no extra latency.

module seg_scan_ctrl #(
    parameter int DWELL = 100000,
    parameter int BLANK = 1000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] digit_data,
    input  logic [7:0]  digit_mask,
    input  logic        load,
    output logic        load_busy,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic        frame_done
);

    // The phase counter must hold the larger of the two phase lengths.
    localparam int MAX_PHASE = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW        = (MAX_PHASE < 1) ? 1 : $clog2(MAX_PHASE + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Scan state.
    state_t        state;
    state_t        state_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Cleared by reset; the first edge after reset release only sets this,
    // so the scan restarts cleanly from digit 0 BLANK on that edge.
    logic          run;

    // Frame boundary strobe for the current edge.
    logic          boundary;

    // Double buffers.
    logic [31:0]   active_data;
    logic [7:0]    active_mask;
    logic [31:0]   pending_data;
    logic [7:0]    pending_mask;

    // Next values of the registered outputs.
    logic [6:0]    out7_next;
    logic [7:0]    en_next;
    logic [3:0]    nibble_next;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan state register: phase, digit index and phase counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_BLANK;
            idx   <= 3'd0;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
            run   <= 1'b1;
        end
    end

    // Next-state logic: count out each phase, advance the digit after SHOW.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        boundary   = 1'b0;
        if (!run) begin
            state_next = ST_BLANK;
            idx_next   = 3'd0;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = ST_SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                        idx_next   = idx + 3'd1;
                        boundary   = (idx == 3'd7);
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    idx_next   = 3'd0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output decode for the state being entered; a masked digit stays dark.
    always_comb begin
        en_next     = 8'hFF;
        out7_next   = 7'h7F;
        nibble_next = active_data[{idx_next, 2'b00} +: 4];
        if (state_next == ST_SHOW && active_mask[idx_next]) begin
            en_next   = ~(8'h01 << idx_next);
            out7_next = decode(nibble_next);
        end
    end

    // Registered display outputs and the frame boundary pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out7       <= 7'h7F;
            en_out     <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            out7       <= out7_next;
            en_out     <= en_next;
            frame_done <= boundary;
        end
    end

    // Double buffer: a load always lands in pending (latest wins); the
    // boundary promotes the old pending value, so a load on that same edge
    // stays pending for the following frame.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pending_data <= 32'h0;
            pending_mask <= 8'h00;
            active_data  <= 32'h0;
            active_mask  <= 8'h00;
            load_busy    <= 1'b0;
        end else begin
            if (load) begin
                pending_data <= digit_data;
                pending_mask <= digit_mask;
            end
            if (boundary && load_busy) begin
                active_data <= pending_data;
                active_mask <= pending_mask;
            end
            if (load) begin
                load_busy <= 1'b1;
            end else if (boundary) begin
                load_busy <= 1'b0;
            end
        end
    end

endmodule
